// File: rtl/lut_mult_pkg.sv
// lut_mult_pkg: shared widths, sequencer state type and saturating add for the LUT multiplier bank
package lut_mult_pkg;
  localparam int W_DIN     = 6;
  localparam int W_PROD    = 11;
  localparam int WCODE_MIN = -32;
  localparam int WCODE_MAX = 31;

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} lms_state_t;

  // acc is sign-extended to 32 bits; the result is clamped to the signed acc_w-bit range
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] acc,
                                                 input logic signed [W_PROD-1:0] prod,
                                                 input int acc_w);
    logic signed [31:0] s, hi, lo;
    s  = acc + 32'(prod);
    hi = (32'sd1 <<< (acc_w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    return s > hi ? hi : s < lo ? lo : s;
  endfunction
endpackage

// File: rtl/lms_weight_table.sv
// lms_weight_table: N_TAPS x 6-bit weight register file, one write port, one async read port
// Ports: clk/rst (async high), i_we/i_waddr/i_wdata write port, i_raddr/o_rdata read port
module lms_weight_table
  import lut_mult_pkg::*;
#(
  parameter int N_TAPS = 16,
  parameter int TAP_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [TAP_W-1:0]  i_waddr,
  input  logic [W_DIN-1:0]  i_wdata,
  input  logic [TAP_W-1:0]  i_raddr,
  output logic [W_DIN-1:0]  o_rdata
);
  logic [W_DIN-1:0] r_mem [N_TAPS];

  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int k = 0; k < N_TAPS; k++) r_mem[k] <= '0;
    else if (i_we)
      r_mem[i_waddr] <= i_wdata;

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/lut_mac_sequencer.sv
// lut_mac_sequencer: drives the shared LUT multiplier bank one tap per cycle and saturating-accumulates a dot product
// Ports: cfg_* weight-table write (IDLE only), s_* activation stream, lut_* bank operand/product,
//        m_* result stream with sticky saturation flag
module lut_mac_sequencer
  import lut_mult_pkg::*;
#(
  parameter int N_TAPS = 16,
  parameter int TAP_W  = 4,
  parameter int ACC_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [TAP_W-1:0]         cfg_addr,
  input  logic [W_DIN-1:0]         cfg_wcode,
  output logic                     cfg_busy,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [W_DIN-1:0]         s_data,
  input  logic                     s_last,
  output logic [W_DIN-1:0]         lut_din,
  output logic [W_DIN-1:0]         lut_wcode,
  input  logic signed [W_PROD-1:0] lut_prod,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [ACC_W-1:0]  m_data,
  output logic                     m_sat
);
  lms_state_t              r_state, w_state_nx;
  logic [TAP_W-1:0]        r_tap;
  logic signed [ACC_W-1:0] r_acc, r_m_data;
  logic                    r_sat, r_m_sat, r_pipe_v, r_s_ready;
  logic [W_DIN-1:0]        r_lut_din, r_lut_wcode, w_wcode;
  logic                    w_accept, w_last, w_ovf;
  logic signed [31:0]      w_raw, w_sum;

  lms_weight_table #(.N_TAPS(N_TAPS), .TAP_W(TAP_W)) u_wtab (
    .clk(clk), .rst(rst),
    .i_we(cfg_we && r_state == IDLE), .i_waddr(cfg_addr), .i_wdata(cfg_wcode),
    .i_raddr(r_tap), .o_rdata(w_wcode)
  );

  assign w_accept = s_valid && r_s_ready;
  assign w_last   = s_last || r_tap == TAP_W'(N_TAPS - 1);
  assign w_raw    = 32'(r_acc) + 32'(lut_prod);
  assign w_sum    = sat_add(32'(r_acc), lut_prod, ACC_W);
  assign w_ovf    = w_sum != w_raw;

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE, ACC: w_state_nx = w_accept ? (w_last ? DRAIN : ACC) : r_state;
      DRAIN:     w_state_nx = OUT;
      OUT:       w_state_nx = m_ready ? IDLE : OUT;
      default:   w_state_nx = IDLE;
    endcase
  end

  // s_ready is registered so it reads 0 while reset is held and rises one cycle after release
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_s_ready   <= 1'b0;
      r_pipe_v    <= 1'b0;
      r_tap       <= '0;
      r_lut_din   <= '0;
      r_lut_wcode <= '0;
      r_acc       <= '0;
      r_sat       <= 1'b0;
      r_m_data    <= '0;
      r_m_sat     <= 1'b0;
    end else begin
      r_s_ready <= w_state_nx == IDLE || w_state_nx == ACC;
      r_pipe_v  <= w_accept;
      if (w_accept) begin
        r_lut_din   <= s_data;
        r_lut_wcode <= w_wcode;
        r_tap       <= w_last ? '0 : r_tap + TAP_W'(1);
      end
      // no add is ever pending in IDLE, so the first beat simply restarts the sum
      if (w_accept && r_state == IDLE) begin
        r_acc <= '0;
        r_sat <= 1'b0;
      end else if (r_pipe_v) begin
        r_acc <= w_sum[ACC_W-1:0];
        r_sat <= r_sat | w_ovf;
      end
      if (r_state == DRAIN) begin
        r_m_data <= w_sum[ACC_W-1:0];
        r_m_sat  <= r_sat | w_ovf;
      end
    end

  assign cfg_busy  = r_state != IDLE;
  assign s_ready   = r_s_ready;
  assign m_valid   = r_state == OUT;
  assign m_data    = r_m_data;
  assign m_sat     = r_m_sat;
  assign lut_din   = r_lut_din;
  assign lut_wcode = r_lut_wcode;
endmodule

// File: tb/tb_lut_mac_sequencer.sv
// tb_lut_mac_sequencer: directed scoreboard bench for lut_mac_sequencer with a multiplier-bank model
module tb_lut_mac_sequencer;
  localparam int N  = 16;
  localparam int AW = 12;

  logic clk = 1'b0, rst = 1'b1, cfg_we = 1'b0, s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1;
  logic [3:0] cfg_addr = '0;
  logic signed [5:0] cfg_wcode = '0, s_data = '0;
  logic cfg_busy, s_ready, m_valid, m_sat;
  logic signed [5:0] lut_din, lut_wcode;
  logic signed [10:0] lut_prod, w_a, w_b;
  logic signed [AW-1:0] m_data;

  int total = 0, bad = 0, cyc = 0, t_last = 0;
  int mw[N];
  int sb_d[$];
  bit sb_s[$];

  lut_mac_sequencer #(.N_TAPS(N), .TAP_W(4), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wcode(cfg_wcode),
    .cfg_busy(cfg_busy), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .lut_din(lut_din), .lut_wcode(lut_wcode), .lut_prod(lut_prod),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sat(m_sat)
  );

  // combinational multiplier bank: product of the registered operand and weight code
  assign w_a = lut_din;
  assign w_b = lut_wcode;
  assign lut_prod = w_a * w_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_m(input int v);
    return v > 2047 ? 2047 : v < -2048 ? -2048 : v;
  endfunction

  task automatic wr(input int a, input int w);
    cfg_we = 1'b1; cfg_addr = 4'(a); cfg_wcode = 6'(w);
    tick();
    cfg_we = 1'b0;
    mw[a] = w;
  endtask

  task automatic beat(input int x, input bit last);
    int n = 0;
    s_valid = 1'b1; s_data = 6'(x); s_last = last;
    while (!s_ready && n < 20) begin tick(); n++; end
    if (!s_ready) chk("s_ready_timeout", 32'(s_ready), 1);
    t_last = cyc;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // wr0: a cfg write to tap 0 presented in the same cycle as the first beat
  task automatic vec(input int n, input int x, input bit wr0 = 1'b0, input int wv = 0);
    int acc = 0, nv;
    bit s = 1'b0;
    for (int i = 0; i < n; i++) begin
      nv = acc + x * mw[i];
      if (nv != sat_m(nv)) s = 1'b1;
      acc = sat_m(nv);
      if (wr0 && i == 0) begin cfg_we = 1'b1; cfg_addr = '0; cfg_wcode = 6'(wv); end
      beat(x, i == n - 1 && n < N);
      cfg_we = 1'b0;
    end
    if (wr0) mw[0] = wv;
    sb_d.push_back(acc);
    sb_s.push_back(s);
  endtask

  task automatic collect(input int hold);
    int n = 0, ed;
    bit es;
    m_ready = hold == 0;
    while (!m_valid && n < 10) begin tick(); n++; end
    chk("m_valid_seen", 32'(m_valid), 1);
    chk("latency", cyc, t_last + 2);
    ed = sb_d.pop_front();
    es = sb_s.pop_front();
    chk("m_data", 32'(m_data), ed);
    chk("m_sat", 32'(m_sat), 32'(es));
    for (int k = 0; k < hold; k++) begin
      cfg_we = 1'b1; cfg_addr = '0; cfg_wcode = -6'sd5;
      tick();
      chk("hold_data", 32'(m_data), ed);
      chk("hold_valid", 32'(m_valid), 1);
      chk("hold_s_ready", 32'(s_ready), 0);
      chk("hold_busy", 32'(cfg_busy), 1);
    end
    cfg_we = 1'b0;
    m_ready = 1'b1;
    tick();
    chk("idle_busy", 32'(cfg_busy), 0);
    chk("idle_m_valid", 32'(m_valid), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 0);
    chk({tag, "_m_valid"}, 32'(m_valid), 0);
    chk({tag, "_busy"}, 32'(cfg_busy), 0);
    chk({tag, "_m_data"}, 32'(m_data), 0);
    chk({tag, "_m_sat"}, 32'(m_sat), 0);
    chk({tag, "_lut_din"}, 32'(lut_din), 0);
    chk({tag, "_lut_wcode"}, 32'(lut_wcode), 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) mw[i] = 0;
    #12;
    chk_reset_outputs("rst");
    @(negedge clk) rst = 1'b0;
    tick(); tick();
    chk("ready_idle", 32'(s_ready), 1);

    vec(16, 5); collect(0);

    for (int i = 0; i < N; i++) wr(i, i - 8);
    vec(16, 3); collect(0);

    for (int i = 0; i < N; i++) wr(i, 7);
    vec(3, -4); collect(0);
    wr(3, -1);
    vec(1, 1); collect(0);

    for (int i = 0; i < N; i++) wr(i, 31);
    vec(16, 31); collect(0);
    vec(16, 0); collect(0);

    vec(2, 1); collect(5);
    vec(1, 1); collect(0);

    vec(1, 1, 1'b1, 2); collect(0);
    vec(1, 1); collect(0);

    for (int i = 0; i < 7; i++) beat(3, 1'b0);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midrst");
    tick();
    chk_reset_outputs("midrst_edge");
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < N; i++) mw[i] = 0;
    tick(); tick();
    vec(16, 5); collect(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
